add_sched32: RTL and testbench

Multi-byte add/subtract sequencer that time-shares one instance of the team's 8-bit ripple-carry adder `rca8b` between two requesters. It accepts a full-width operation from the granted requester and walks the operand bytes LSB-first through the adder, one byte per cycle, chaining the carry in a register. It returns sum, carry-out and signed overflow on a valid/ready response port. It sits between the ALU front-end requesters and the shared 8-bit adder datapath.

---
 rtl/add_sched32.sv | 189 ++++++++++++++++++
 tb/tb_add_sched32.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sched32.sv
`timescale 1ns/1ps
// add_sched32: two-requester multi-byte add/subtract sequencer that walks
// operand bytes LSB-first through one shared 8-bit ripple-carry adder.

// 8-bit ripple-carry adder shared by both requesters.
module rca8b (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] c;

  // Ripple the carry bit by bit.
  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < 8; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[8];
  end

endmodule

module add_sched32 #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_sub,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_cout,
  output logic                rsp_ovf,
  output logic                busy
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned KW = $clog2(NBYTES);
  localparam int unsigned BW = KW + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          lg_q, lg_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic          id_q, id_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          grant0, grant1;
  logic          acc0, acc1;
  logic          last_byte;
  logic [BW-1:0] bidx;
  logic [7:0]    add_a, add_b, add_s;
  logic          add_cin, add_cout;

  // Round-robin: on contention the requester that did not win last goes first.
  assign grant0 = req0_valid & (~req1_valid | lg_q);
  assign grant1 = req1_valid & (~req0_valid | ~lg_q);

  assign req0_ready = (state_q == IDLE) & grant0 & ~rst;
  assign req1_ready = (state_q == IDLE) & grant1 & ~rst;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  // Byte k operand select; subtract is A + ~B + 1 with the +1 as first carry-in.
  assign bidx      = {k_q, 3'b000};
  assign last_byte = (k_q == KW'(NBYTES - 1));
  assign add_a     = a_q[bidx +: 8];
  assign add_b     = b_q[bidx +: 8] ^ {8{sub_q}};
  assign add_cin   = (k_q == '0) ? sub_q : carry_q;

  rca8b u_rca8b (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_s),
    .cout_o (add_cout)
  );

  // Next-state: accept in IDLE, one byte per cycle in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    id_d    = id_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (acc0 | acc1) begin
          a_d     = acc1 ? req1_a   : req0_a;
          b_d     = acc1 ? req1_b   : req0_b;
          sub_d   = acc1 ? req1_sub : req0_sub;
          id_d    = acc1;
          lg_d    = acc1;
          k_d     = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[bidx +: 8] = add_s;
        carry_d          = add_cout;
        k_d              = k_q + KW'(1);
        if (last_byte) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] ~^ add_b[7]) & (add_s[7] ^ a_q[W-1]);
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_add_sched32.sv
`timescale 1ns/1ps
// tb_add_sched32: randomized and directed checks of add_sched32 against an
// arithmetic reference model.
module tb_add_sched32;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [W-1:0] rsp_sum;

  int   errors = 0;
  int   checks = 0;
  logic lg_m;

  add_sched32 #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    longint       sa, sb, r, lim;
    logic [W-1:0] s;
    logic         c;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) <<< (W - 1);
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = sa - sb;
    end else begin
      s = a + b;
      c = ((64'(a) + 64'(b)) >> W) != 64'd0;
      r = sa + sb;
    end
    return {((r >= lim) || (r < -lim)), c, s};
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, "_r0rdy"}, req0_ready, 0);
    check_eq({tag, "_r1rdy"}, req1_ready, 0);
    check_eq({tag, "_valid"}, rsp_valid, 0);
    check_eq({tag, "_id"},    rsp_id, 0);
    check_eq({tag, "_sum"},   rsp_sum, 0);
    check_eq({tag, "_cout"},  rsp_cout, 0);
    check_eq({tag, "_ovf"},   rsp_ovf, 0);
    check_eq({tag, "_busy"},  busy, 0);
  endtask

  task automatic check_rsp(input logic eid, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub);
    logic [W+1:0] m;
    m = model(a, b, sub);
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_id",    rsp_id, eid);
    check_eq("rsp_sum",   rsp_sum, m[W-1:0]);
    check_eq("rsp_cout",  rsp_cout, m[W]);
    check_eq("rsp_ovf",   rsp_ovf, m[W+1]);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("rsp_drop", rsp_valid, 0);
  endtask

  // One full operation from the given valid pattern; rdly = cycles of backpressure.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                       input int rdly);
    logic g;
    int   n;
    int   lat;
    g = (v0 & v1) ? ~lg_m : v1;
    @(posedge clk); #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    #1;
    n = 0;
    while (!(g ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("grant",       g ? req1_ready : req0_ready, 1);
    check_eq("grant_other", g ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lg_m = g;
    check_eq("busy_run", busy, 1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, NB);
    check_rsp(g, g ? a1 : a0, g ? b1 : b0, g ? s1 : s0);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      check_rsp(g, g ? a1 : a0, g ? b1 : b0, g ? s1 : s0);
    end
    take_rsp();
  endtask

  // Both readies must never be high together.
  always @(negedge clk) begin
    if (req0_ready | req1_ready) check_eq("ready_excl", req0_ready & req1_ready, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ta, tb;
    logic         ts;
    logic [1:0]   vp;

    rst = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready  = 1'b0;
    lg_m = 1'b1;
    #12;
    check_zero("rst_init");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Carry chain, subtract and overflow corners
    do_op(1, 0, 32'h0000_00FF, 32'h0000_0001, 0, '0, '0, 0, 0);
    do_op(1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 0, '0, '0, 0, 0);
    do_op(0, 1, '0, '0, 0, 32'h0000_0000, 32'h0000_0001, 1, 1);
    do_op(1, 0, 32'h8000_0000, 32'h0000_0001, 1, '0, '0, 0, 0);
    do_op(1, 0, 32'h7FFF_FFFF, 32'h0000_0001, 0, '0, '0, 0, 2);

    // Backpressure with req1 waiting
    ta = $urandom; tb = $urandom;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = ta; req0_b = tb; req0_sub = 1'b0;
    #1;
    check_eq("bp_grant", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    lg_m = 1'b0;
    repeat (NB) @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h1234_5679; req1_sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check_rsp(0, ta, tb, 1'b0);
      check_eq("bp_r1rdy", req1_ready, 0);
      check_eq("bp_r0rdy", req0_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    check_eq("bp_release_valid", rsp_valid, 0);
    check_eq("bp_release_r1rdy", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    lg_m = 1'b1;
    repeat (NB) @(posedge clk);
    #1;
    check_rsp(1, 32'h1234_5678, 32'h1234_5679, 1'b1);
    take_rsp();

    // Asynchronous reset at a random point of RUN or DONE with random inputs
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
      #1;
      check_eq("rr_grant", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat ($urandom_range(1, NB + 2)) @(posedge clk);
      #3;
      req0_valid = 1'($urandom); req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
      req1_valid = 1'($urandom); req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
      rsp_ready  = 1'($urandom);
      rst = 1'b1;
      #1;
      check_zero("rst_mid");
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      #1;
      rst = 1'b0;
      lg_m = 1'b1;
    end

    // Arbitration with both valid: 0,1,0 after reset
    for (int i = 0; i < 3; i++) begin
      do_op(1, 1, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 0);
    end

    // Reset after two bytes of a req1 operation drops it
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
    #1;
    check_eq("rmo_grant", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero("rst_run");
    @(posedge clk); #1;
    rst = 1'b0;
    lg_m = 1'b1;
    for (int i = 0; i < NB + 3; i++) begin
      @(posedge clk); #1;
      check_eq("rmo_no_rsp", rsp_valid, 0);
      check_eq("rmo_idle", busy, 0);
    end
    do_op(1, 1, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 0);

    // Randomized operations and request patterns
    for (int i = 0; i < 30; i++) begin
      vp = 2'($urandom_range(1, 3));
      do_op(vp[0], vp[1], $urandom, $urandom, 1'($urandom), $urandom, $urandom,
            1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
